sprite_reader: RTL and testbench
================================

SPRITE_READER -- requirements
Module: sprite_reader

Interface
REQ-001 Parameter IMG_W, default 90: sprite width in pixels.
REQ-002 Parameter IMG_H, default 90: sprite height in pixels; IMG_W*IMG_H SHALL be at most 8192.
REQ-003 Parameter KEY, default 16'hF81F: RGB565 transparency key colour.
REQ-004 clk  in  1: single clock, rising edge; shared with the image ROM clka.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 start  in  1: one-cycle request to stream the sprite.
REQ-007 origin_x  in  10: screen X of the sprite's top-left corner; sampled only on an accepted start.
REQ-008 origin_y  in  10: screen Y of the sprite's top-left corner; sampled only on an accepted start.
REQ-009 rom_addr  out  13: word address to the image ROM.
REQ-010 rom_data  in  16: ROM read data, valid exactly 1 cycle after rom_addr is presented.
REQ-011 pix_valid  out  1: output pixel available.
REQ-012 pix_ready  in  1: downstream accepts the pixel when pix_valid is also high.
REQ-013 pix_data  out  16: RGB565 pixel value.
REQ-014 pix_x  out  10: screen X of the pixel.
REQ-015 pix_y  out  10: screen Y of the pixel.
REQ-016 pix_key  out  1: pix_data equals KEY.
REQ-017 pix_last  out  1: the pixel is the final pixel of the sprite (col IMG_W-1, row IMG_H-1).
REQ-018 busy  out  1: high from an accepted start until done.
REQ-019 done  out  1: one-cycle pulse after the final pixel is accepted.

Function
REQ-020 The block SHALL use the FSM states IDLE, FETCH, DRAIN and DONE.
REQ-021 IDLE->FETCH on start; origin_x/origin_y SHALL be latched and the issue counter cleared at that point.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 In FETCH, one read SHALL be issued per cycle only while (buffer occupancy + reads in flight) < 2.
REQ-024 On an issue, rom_addr SHALL be registered to the issue index, with addresses ascending row-major from 0 to IMG_W*IMG_H-1.
REQ-025 rom_data SHALL be captured into a 2-entry FIFO on the cycle after each issue, together with its col, row and last tag.
REQ-026 FETCH->DRAIN on the issue of address IMG_W*IMG_H-1.
REQ-027 DRAIN->DONE when the last-tagged entry is accepted (pix_valid && pix_ready).
REQ-028 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-029 The FIFO head SHALL drive pix_*; pix_valid SHALL equal FIFO non-empty, and output SHALL be in order with no drop or duplication.
REQ-030 pix_x SHALL equal (origin_x + col) mod 1024, and pix_y SHALL equal (origin_y + row) mod 1024, with no saturation.
REQ-031 The column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter at the same time.
REQ-032 pix_key SHALL be combinational on pix_data == KEY.
REQ-033 When the FIFO is full and not popping, no issue SHALL occur; a push and a pop in the same cycle SHALL keep occupancy unchanged.
REQ-034 With pix_ready held high, throughput SHALL be 1 pixel per cycle; first pix_valid SHALL appear 3 cycles after start (start sampled, issue, capture).
REQ-035 While pix_valid is high and pix_ready is low, pix_data, pix_x, pix_y, pix_key and pix_last SHALL be held stable.

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE, FIFO empty, counters=0.
REQ-037 On rst_n low, asynchronously: rom_addr=0, pix_valid=0, busy=0, done=0, pix_data/pix_x/pix_y=0.
REQ-038 Reset mid-stream SHALL abort the stream; after release the block SHALL be idle and emit no stale pixels.

Verification
REQ-039 rst_n release, start with origin (100,50), pix_ready=1 -> 8100 pixels at 1 per cycle; first pixel (100,50) with data=ROM[0]; last pixel (189,139) with pix_last=1; done pulses once.
REQ-040 pix_ready toggled pseudo-randomly -> output sequence identical to ROM[0..8099]; outputs stable while stalled; at most 2 reads outstanding.
REQ-041 origin (1000,1000) -> pixel index 30 reports (6,1000); pixel index 90 reports (1000,1001).
REQ-042 start pulsed while busy -> ignored; exactly 8100 pixels; done pulses once.
REQ-043 ROM word = 16'hF81F -> pix_key=1 on exactly that pixel.
REQ-044 rst_n low at pixel 4000 -> all outputs reset within the same cycle; a new start then streams from address 0.

Source files
------------

// File: rtl/sprite_reader.sv
// Streams a sprite from a 1-cycle-latency image ROM as screen-positioned RGB565 pixels
// through a 2-entry FIFO with valid/ready handshake.
module sprite_reader #(
  parameter int          IMG_W = 90,
  parameter int          IMG_H = 90,
  parameter logic [15:0] KEY   = 16'hF81F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  origin_x,
  input  logic [9:0]  origin_y,
  output logic [12:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_key,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam logic [12:0] LAST_ADDR = 13'(IMG_W * IMG_H - 1);
  localparam logic [12:0] COL_MAX   = 13'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [9:0]  org_x, org_y;
  logic [12:0] idx, col, row;
  logic        inflight, fl_last;
  logic [9:0]  fl_col, fl_row;
  logic [15:0] f_data [2];
  logic [9:0]  f_x    [2];
  logic [9:0]  f_y    [2];
  logic        f_last [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        pop, issue;

  assign pix_valid = (count != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = f_data[rd_ptr];
  assign pix_x     = f_x[rd_ptr];
  assign pix_y     = f_y[rd_ptr];
  assign pix_last  = f_last[rd_ptr];
  assign pix_key   = (pix_data == KEY);
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);

  // A pop this cycle frees a slot, which is what sustains one pixel per cycle.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: begin
        if (({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2) issue = 1'b1;
        if (issue && (idx == LAST_ADDR)) state_nx = DRAIN;
      end
      DRAIN: if (pop && pix_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      org_x    <= '0;
      org_y    <= '0;
      idx      <= '0;
      col      <= '0;
      row      <= '0;
      rom_addr <= '0;
      inflight <= 1'b0;
      fl_col   <= '0;
      fl_row   <= '0;
      fl_last  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_x[i]    <= '0;
        f_y[i]    <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (state == IDLE && start) begin
        org_x <= origin_x;
        org_y <= origin_y;
        idx   <= '0;
        col   <= '0;
        row   <= '0;
      end
      if (issue) begin
        rom_addr <= idx;
        idx      <= idx + 13'd1;
        fl_col   <= col[9:0];
        fl_row   <= row[9:0];
        fl_last  <= (idx == LAST_ADDR);
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + 13'd1;
        end else begin
          col <= col + 13'd1;
        end
      end
      // ROM data belongs to the address issued on the previous cycle.
      if (inflight) begin
        f_data[wr_ptr] <= rom_data;
        f_x[wr_ptr]    <= org_x + fl_col;
        f_y[wr_ptr]    <= org_y + fl_row;
        f_last[wr_ptr] <= fl_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sprite_reader.sv
// Directed bench for sprite_reader: table of streams with probed pixels, full per-pixel
// model comparison, plus busy-start, key and mid-stream reset sequences.
module tb_sprite_reader;

  localparam int          W = 90;
  localparam int          H = 90;
  localparam int          N = W * H;
  localparam logic [15:0] KEYC = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst_n, start, pix_ready;
  logic [9:0]  origin_x, origin_y;
  logic [12:0] rom_addr;
  logic [15:0] rom_data;
  logic        pix_valid, pix_key, pix_last, busy, done;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;

  logic [15:0] rom [8192];

  sprite_reader #(.IMG_W(W), .IMG_H(H), .KEY(KEYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_key(pix_key),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  typedef struct {
    int ox, oy;
    bit rnd, poke;
    int probe, ex, ey;
  } vec_t;

  int  nvec = 0, nerr = 0;
  bit  mon_en = 0, rnd_mode = 0, hold_pending = 0;
  int  k, done_cnt, key_cnt, max_lead, probe_idx, probe_x, probe_y, m_ox, m_oy;
  longint held;

  task automatic checkOutput(string name, longint act, longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic longint pack_out();
    return {22'd0, pix_data, pix_x, pix_y, pix_last, pix_key};
  endfunction

  function automatic longint model_pix(int idx);
    logic [15:0] d;
    logic [9:0]  x, y;
    d = rom[idx];
    x = 10'((m_ox + idx % W) & 1023);
    y = 10'((m_oy + idx / W) & 1023);
    return {22'd0, d, x, y, (idx == N - 1), (d == KEYC)};
  endfunction

  // Output monitor: checks every accepted pixel, stall stability and issue lead.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_valid && hold_pending) checkOutput("stall_hold", pack_out(), held);
      hold_pending = pix_valid && !pix_ready;
      held = pack_out();
      if (k > 0 && int'(rom_addr) - k > max_lead) max_lead = int'(rom_addr) - k;
      if (pix_valid && pix_ready) begin
        if (k < N) checkOutput("pixel", pack_out(), model_pix(k));
        if (k == probe_idx) begin
          probe_x = int'(pix_x);
          probe_y = int'(pix_y);
        end
        if (pix_key) key_cnt++;
        k++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic monitorArm(int ox, int oy, int probe);
    m_ox = ox; m_oy = oy; probe_idx = probe;
    k = 0; done_cnt = 0; key_cnt = 0; max_lead = 0; hold_pending = 0;
    probe_x = -1; probe_y = -1;
    mon_en = 1;
  endtask

  task automatic applyStimulus(vec_t v);
    int n, first;
    bit finished;
    monitorArm(v.ox, v.oy, v.probe);
    rnd_mode = v.rnd;
    @(posedge clk);
    #1;
    start = 1'b1; origin_x = 10'(v.ox); origin_y = 10'(v.oy);
    n = 0; first = -1; finished = 0;
    while (!finished && n < 40000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (v.poke && n == 100) begin
        start = 1'b1; origin_x = 10'd0; origin_y = 10'd0;
      end
      if (v.poke && n == 101) start = 1'b0;
      if (first < 0 && pix_valid) first = n;
      if (done) finished = 1;
    end
    checkOutput("stream_timeout", finished, 1);
    checkOutput("first_valid_latency", first, 3);
    if (!v.rnd) checkOutput("full_rate_cycles", n, N + 3);
    rnd_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    mon_en = 0;
    checkOutput("pixel_count", k, N);
    checkOutput("probe_x", probe_x, v.ex);
    checkOutput("probe_y", probe_y, v.ey);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("key_pixels", key_cnt, 1);
    checkOutput("max_outstanding_lead", max_lead, 1);
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_rom_addr"}, rom_addr, 0);
    checkOutput({tag, "_pix_valid"}, pix_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pix_xy_data"}, {pix_data, pix_x, pix_y}, 0);
  endtask

  vec_t tbl[5];
  int   n;

  initial begin
    tbl[0] = '{ox: 100,  oy: 50,   rnd: 0, poke: 0, probe: 0,    ex: 100,  ey: 50};
    tbl[1] = '{ox: 100,  oy: 50,   rnd: 0, poke: 0, probe: 8099, ex: 189,  ey: 139};
    tbl[2] = '{ox: 1000, oy: 1000, rnd: 1, poke: 0, probe: 30,   ex: 6,    ey: 1000};
    tbl[3] = '{ox: 1000, oy: 1000, rnd: 0, poke: 1, probe: 90,   ex: 1000, ey: 1001};
    tbl[4] = '{ox: 1023, oy: 1023, rnd: 1, poke: 0, probe: 91,   ex: 0,    ey: 0};

    for (int i = 0; i < 8192; i++) begin
      rom[i] = 16'(i * 40503 + 12345) ^ 16'(i >> 3);
      if (rom[i] == KEYC) rom[i] = 16'h1234;
    end
    rom[500] = KEYC;

    rst_n = 1'b0; start = 1'b0; origin_x = '0; origin_y = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(tbl[i]);

    // Abort a stream with reset part way through, then restart from address 0.
    monitorArm(100, 50, -1);
    @(posedge clk);
    #1;
    start = 1'b1; origin_x = 10'd100; origin_y = 10'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (k < 4000 && n < 9000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("abort_reached_4000", k >= 4000, 1);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midstream_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale_pixel", pix_valid, 0);
    end
    checkOutput("idle_after_abort", busy, 0);
    applyStimulus(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
